// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Single-port data-memory responder with byte lanes and RMW stores.
//  Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_byte_enable,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_RMW  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                oor_q, oor_d;

    logic [31:0]         mem_q [0:DEPTH-1];
    logic [31:0]         rdword_q;

    logic                w_accept;
    logic [ADDR_W-1:0]   w_req_idx;
    logic                w_req_oor;
    logic                w_mem_we;
    logic                w_mem_re;
    logic [ADDR_W-1:0]   w_mem_waddr;
    logic [31:0]         w_mem_wdata;
    logic [31:0]         w_merged;
    logic                w_unused_addr;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    assign w_req_idx     = req_addr[ADDR_W+1:2];
    assign w_req_oor     = |req_addr[31:ADDR_W+2];
    assign w_unused_addr = ^req_addr[1:0];

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    assign w_merged = (rdword_q & ~lane_mask(be_q)) | (wdata_q & lane_mask(be_q));

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        idx_d       = idx_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        oor_d       = oor_q;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_waddr = idx_q;
        w_mem_wdata = w_merged;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    write_d = req_write;
                    idx_d   = w_req_idx;
                    be_d    = req_byte_enable;
                    wdata_d = req_wdata;
                    oor_d   = w_req_oor;
                    if (w_req_oor) begin
                        state_d = S_RESP;
                    end else if (req_write && (req_byte_enable == 4'b1111)) begin
                        // Full-word store needs no old data: commit on the accepting edge.
                        w_mem_we    = 1'b1;
                        w_mem_waddr = w_req_idx;
                        w_mem_wdata = req_wdata;
                        state_d     = S_RESP;
                    end else if (req_write && (req_byte_enable == 4'b0000)) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                w_mem_re = 1'b1;
                state_d  = write_q ? S_RMW : S_RESP;
            end
            S_RMW: begin
                w_mem_we = 1'b1;
                state_d  = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A reset landing on the RMW edge must not commit the merged word.
        if (reset) begin
            w_mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            idx_q   <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
        end
    end

    // Single synchronous port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_waddr] <= w_mem_wdata;
        end else if (w_mem_re) begin
            rdword_q <= mem_q[idx_q];
        end
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_error = (state_q == S_RESP) && oor_q;
    assign resp_rdata = ((state_q == S_RESP) && !write_q && !oor_q)
                        ? (rdword_q & lane_mask(be_q)) : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// Self-checking bench for dmem_responder: scoreboarded requests, reset and back-to-back scenarios.
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_byte_enable;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    int    n_checks;
    int    n_pass;
    resp_t sb[$];

    dmem_responder #(.ADDR_W(10)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_byte_enable (req_byte_enable),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_error      (resp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request, push its expected response, then wait for and compare it.
    task automatic send(input logic w, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat, input string name);
        int    k;
        bit    got;
        resp_t e;
        @(negedge clk);
        req_write       = w;
        req_addr        = a;
        req_byte_enable = be;
        req_wdata       = wd;
        req_valid       = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!req_ready) begin
            $display("FAIL %s_ready: req_ready=%0b required 1", name, req_ready);
            req_valid = 1'b0;
            return;
        end
        n_pass++;
        sb.push_back('{rdata: exp_rd, err: exp_err});
        @(posedge clk);
        got = 1'b0;
        for (int n = 1; n <= 10 && !got; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            if (resp_valid) begin
                got = 1'b1;
                e = sb.pop_front();
                n_checks++;
                if (resp_rdata !== e.rdata)
                    $display("FAIL %s_rdata: got %08h required %08h", name, resp_rdata, e.rdata);
                else n_pass++;
                n_checks++;
                if (resp_error !== e.err)
                    $display("FAIL %s_error: got %0b required %0b", name, resp_error, e.err);
                else n_pass++;
                n_checks++;
                if (n != exp_lat)
                    $display("FAIL %s_latency: got %0d required %0d", name, n, exp_lat);
                else n_pass++;
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL %s_timeout: resp_valid=0 required 1 within 10 edges", name);
            if (sb.size() > 0) e = sb.pop_front();
            return;
        end
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0)
            $display("FAIL %s_pulse: resp_valid=%0b required 0", name, resp_valid);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset           = 1'b1;
        req_valid       = 1'b1;
        req_write       = 1'b0;
        req_addr        = 32'h0;
        req_byte_enable = 4'hF;
        req_wdata       = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready: got %0b required 0", req_ready);
        else n_pass++;
        n_checks++;
        if (resp_valid !== 1'b0) $display("FAIL reset_valid: got %0b required 0", resp_valid);
        else n_pass++;
        n_checks++;
        if (resp_rdata !== 32'h0 || resp_error !== 1'b0)
            $display("FAIL reset_resp: got %08h/%0b required 00000000/0", resp_rdata, resp_error);
        else n_pass++;
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b required 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_full_store_load;
        send(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1, "full_store");
        send(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 2, "full_load");
    endtask

    task automatic test_partial_store;
        send(1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0, 1, "pre_store");
        send(1'b1, 32'h20, 4'b0010, 32'h0000AA00, 32'h0, 1'b0, 3, "partial_store");
        send(1'b0, 32'h20, 4'hF, 32'h0, 32'h1122AA44, 1'b0, 2, "partial_load");
        send(1'b1, 32'h20, 4'b1001, 32'h55FFFF66, 32'h0, 1'b0, 3, "partial_store2");
        send(1'b0, 32'h20, 4'hF, 32'h0, 32'h5522AA66, 1'b0, 2, "partial_load2");
    endtask

    task automatic test_load_mask;
        send(1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1, "mask_store");
        send(1'b0, 32'h30, 4'b1100, 32'h0, 32'hCAFE0000, 1'b0, 2, "mask_load_hi");
        send(1'b0, 32'h33, 4'b0001, 32'h0, 32'h0000000D, 1'b0, 2, "mask_load_lo");
    endtask

    task automatic test_empty_store;
        send(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1, "empty_store");
        send(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 2, "empty_check");
    endtask

    task automatic test_out_of_range;
        send(1'b1, 32'h0, 4'hF, 32'h0BADCAFE, 32'h0, 1'b0, 1, "word0_store");
        send(1'b1, 32'h1000, 4'hF, 32'h12345678, 32'h0, 1'b1, 1, "oor_store");
        send(1'b0, 32'h8000_0000, 4'hF, 32'h0, 32'h0, 1'b1, 1, "oor_load");
        send(1'b0, 32'h0, 4'hF, 32'h0, 32'h0BADCAFE, 1'b0, 2, "word0_load");
    endtask

    task automatic test_reset_mid_rmw;
        bit seen;
        send(1'b1, 32'h40, 4'hF, 32'h55667788, 32'h0, 1'b0, 1, "rst_pre_store");
        @(negedge clk);
        req_write       = 1'b1;
        req_addr        = 32'h40;
        req_byte_enable = 4'b0001;
        req_wdata       = 32'h000000AA;
        req_valid       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL rst_mid_ready: got %0b required 0", req_ready);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL rst_after_ready: got %0b required 1", req_ready);
        else n_pass++;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (resp_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen) $display("FAIL rst_no_resp: resp_valid seen=1 required 0");
        else n_pass++;
        send(1'b0, 32'h40, 4'hF, 32'h0, 32'h55667788, 1'b0, 2, "rst_word_unchanged");
    endtask

    task automatic test_back_to_back;
        int    acc;
        int    rsp;
        int    first_c;
        int    second_c;
        resp_t e;
        acc = 0; rsp = 0; first_c = 0; second_c = 0;
        @(negedge clk);
        req_write       = 1'b0;
        req_addr        = 32'h10;
        req_byte_enable = 4'hF;
        req_wdata       = 32'h0;
        req_valid       = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (resp_valid) begin
                rsp++;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL b2b_extra_resp: got unexpected resp_valid at step %0d", c);
                end else begin
                    e = sb.pop_front();
                    if (resp_rdata !== e.rdata)
                        $display("FAIL b2b_rdata: got %08h required %08h", resp_rdata, e.rdata);
                    else n_pass++;
                end
            end
            if (acc == 2) begin
                req_valid = 1'b0;
            end else if (req_ready) begin
                acc++;
                if (acc == 1) begin
                    first_c = c;
                    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
                end else begin
                    second_c = c;
                    sb.push_back('{rdata: 32'h5522AA66, err: 1'b0});
                end
            end else if (acc == 1) begin
                req_addr = 32'h20;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_checks++;
        if (acc != 2) $display("FAIL b2b_accepts: got %0d required 2", acc);
        else n_pass++;
        n_checks++;
        if (rsp != 2) $display("FAIL b2b_responses: got %0d required 2", rsp);
        else n_pass++;
        n_checks++;
        if (second_c - first_c != 3)
            $display("FAIL b2b_spacing: got %0d required 3", second_c - first_c);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL b2b_leftover: got %0d required 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_full_store_load();
        test_partial_store();
        test_load_mask();
        test_empty_store();
        test_out_of_range();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
